// File: rtl/calc_program_loader.sv
// rtl/calc_program_loader.sv - host-side program buffer and result capture for the 16-slot calculator
// Buffers host words, pulses calc_reset, streams 16 words to DIN, then captures 16 results.
module calc_program_loader #(
  parameter int DEPTH          = 16,
  parameter int INSTR_W        = 18,
  parameter int RES_W          = 16,
  parameter int RESULT_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_valid,
  input  logic [INSTR_W-1:0] host_instr,
  output logic               host_ready,
  input  logic               start,
  output logic               calc_reset,
  output logic [INSTR_W-1:0] calc_din,
  input  logic [RES_W-1:0]   calc_result,
  input  logic               calc_neg,
  output logic               busy,
  output logic               done,
  output logic [4:0]         count,
  input  logic [3:0]         rd_addr,
  output logic [RES_W:0]     rd_data
);

  // Shared phase counter must also span the WAIT phase for large latencies.
  localparam int CW = (RESULT_LATENCY > 15) ? $clog2(RESULT_LATENCY + 1) : 4;

  typedef enum logic [2:0] {
    S_FILL, S_RESET_CALC, S_SEND, S_WAIT, S_CAPTURE, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4:0]           count_q, count_d;
  logic                 calc_reset_q, calc_reset_d;
  logic [INSTR_W-1:0]   calc_din_q, calc_din_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [RES_W:0]       rd_data_q;
  logic                 accept;
  logic [INSTR_W-1:0]   instr_buf_q  [DEPTH];
  logic [RES_W:0]       result_buf_q [DEPTH];

  assign host_ready = (state_q == S_FILL) && !count_q[4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    accept  = 1'b0;
    case (state_q)
      S_FILL: begin
        accept = host_valid && host_ready;
        if (accept) count_d = count_q + 5'd1;
        if ((accept && count_q == 5'd15) || (start && count_d != 5'd0))
          state_d = S_RESET_CALC;
      end
      S_RESET_CALC: begin
        state_d = S_SEND;
        cnt_d   = '0;
      end
      S_SEND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(15)) begin
          cnt_d   = '0;
          state_d = (RESULT_LATENCY == 0) ? S_CAPTURE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RESULT_LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(15)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          count_d = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase

    // Outputs are registered, so they are derived from the next state.
    calc_reset_d = (state_d == S_RESET_CALC);
    busy_d       = (state_d == S_RESET_CALC) || (state_d == S_SEND) ||
                   (state_d == S_WAIT) || (state_d == S_CAPTURE);
    done_d       = (state_d == S_DONE);
    calc_din_d   = '0;
    if (state_d == S_SEND && {1'b0, cnt_d[3:0]} < count_d)
      calc_din_d = instr_buf_q[cnt_d[3:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FILL;
      cnt_q        <= '0;
      count_q      <= '0;
      calc_reset_q <= 1'b0;
      calc_din_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_data_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_buf_q[i]  <= '0;
        result_buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      calc_reset_q <= calc_reset_d;
      calc_din_q   <= calc_din_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      if (accept) instr_buf_q[count_q[3:0]] <= host_instr;
      if (state_q == S_CAPTURE) result_buf_q[cnt_q[3:0]] <= {calc_neg, calc_result};
      rd_data_q    <= result_buf_q[rd_addr];
    end
  end

  assign calc_reset = calc_reset_q;
  assign calc_din   = calc_din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign count      = count_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_calc_program_loader.sv
// tb/tb_calc_program_loader.sv - scoreboard bench for calc_program_loader
// Two instances (latency 2 and latency 0) share stimulus; a calculator model drives results.
module tb_calc_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_valid;
  logic [17:0] host_instr;
  logic        start;
  logic [3:0]  rd_addr;
  logic [15:0] calc_result = '0, calc_result0 = '0;
  logic        calc_neg = 1'b0, calc_neg0 = 1'b0;
  logic [15:0] res_base = 16'h2000;

  logic        host_ready, calc_reset, busy, done;
  logic [17:0] calc_din;
  logic [4:0]  count;
  logic [16:0] rd_data;
  logic        host_ready0, calc_reset0, busy0, done0;
  logic [17:0] calc_din0;
  logic [4:0]  count0;
  logic [16:0] rd_data0;

  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  calc_program_loader #(.RESULT_LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_instr(host_instr),
    .host_ready(host_ready), .start(start), .calc_reset(calc_reset), .calc_din(calc_din),
    .calc_result(calc_result), .calc_neg(calc_neg), .busy(busy), .done(done),
    .count(count), .rd_addr(rd_addr), .rd_data(rd_data));

  calc_program_loader #(.RESULT_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_instr(host_instr),
    .host_ready(host_ready0), .start(start), .calc_reset(calc_reset0), .calc_din(calc_din0),
    .calc_result(calc_result0), .calc_neg(calc_neg0), .busy(busy0), .done(done0),
    .count(count0), .rd_addr(rd_addr), .rd_data(rd_data0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(output int c, output int c0);
    c  = 0;
    c0 = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done0 && c0 == 0) c0 = i;
      if (done) begin
        c = i;
        break;
      end
    end
  endtask

  // Monitor: after each calc_reset pulse, compare the 16 DIN words against the queue.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!reset && calc_reset === 1'b1) begin
        chk("din_in_reset", calc_din, 0);
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          if (reset) break;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL din_underflow: word %0d got %0h with no expected value", i, calc_din);
          end else begin
            e = exp_q.pop_front();
            chk("din_word", calc_din, e);
          end
          if (i == 0) chk("calc_reset_width", calc_reset, 0);
        end
        if (!reset) begin
          @(negedge clk);
          if (!reset) chk("din_after_send", calc_din, 0);
        end
      end
    end
  end

  // Calculator model: result for capture slot k is res_base+k, NEG is k[0].
  initial begin
    int k, k0;
    forever begin
      @(negedge clk);
      if (!reset && calc_reset === 1'b1) begin
        for (int t = 1; t <= 36; t++) begin
          @(posedge clk);
          #1;
          if (reset) break;
          k  = t - 19;
          k0 = t - 17;
          calc_result  = res_base + 16'(k);
          calc_neg     = k[0];
          calc_result0 = res_base + 16'(k0);
          calc_neg0    = k0[0];
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int c, c0;
    logic [16:0] ev;
    logic [17:0] w;
    reset = 1'b1; host_valid = 1'b0; host_instr = '0; start = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_din", calc_din, 0);
    chk("rst_calc_reset", calc_reset, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_host_ready", host_ready, 1);
    reset = 1'b0;
    tick();

    // start with empty buffer is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_start_busy", busy, 0);
    chk("empty_start_count", count, 0);
    tick();
    chk("empty_start_ready", host_ready, 1);
    chk("empty_start_calc_reset", calc_reset, 0);

    // full program, auto-start on the 16th word
    res_base = 16'h2000;
    for (int k = 0; k < 16; k++) exp_q.push_back({2'b00, 8'(k), 8'd1});
    host_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      host_instr = {2'b00, 8'(k), 8'd1};
      tick();
    end
    host_valid = 1'b0;
    chk("full_host_ready", host_ready, 0);
    chk("full_count", count, 16);
    chk("full_calc_reset", calc_reset, 1);
    run_to_done(c, c0);
    chk("full_done_cycles", c, 35);
    chk("full_done_cycles_lat0", c0, 33);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      ev = {1'(a & 1), 16'h2000 + 16'(a)};
      chk("full_rd", rd_data, ev);
      chk("full_rd_lat0", rd_data0, ev);
    end

    // acknowledge: back to FILL, old results still readable
    start = 1'b1; tick(); start = 1'b0;
    chk("ack_done", done, 0);
    chk("ack_count", count, 0);
    chk("ack_ready", host_ready, 1);
    rd_addr = 4'd3; tick();
    chk("ack_rd_retained", rd_data, 17'h12003);

    // partial program: 3 words, then start; host_valid during the run is ignored
    res_base = 16'h1000;
    exp_q.push_back(18'h1A5C3); exp_q.push_back(18'h2F00F); exp_q.push_back(18'h30001);
    for (int k = 0; k < 13; k++) exp_q.push_back(18'h0);
    host_valid = 1'b1;
    host_instr = 18'h1A5C3; tick();
    host_instr = 18'h2F00F; tick();
    host_instr = 18'h30001; tick();
    host_valid = 1'b0;
    chk("part_count", count, 3);
    chk("part_no_autostart", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    host_valid = 1'b1; host_instr = 18'h3FFFF;
    run_to_done(c, c0);
    host_valid = 1'b0;
    chk("part_done_cycles", c, 35);
    chk("part_done_cycles_lat0", c0, 33);
    chk("part_count_kept", count, 3);
    rd_addr = 4'd5; tick();
    chk("part_rd5", rd_data, 17'h11005);
    chk("part_rd5_lat0", rd_data0, 17'h11005);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      ev = {1'(a & 1), 16'h1000 + 16'(a)};
      chk("overwrite_rd", rd_data, ev);
    end

    // push and start in the same cycle with two words already buffered
    start = 1'b1; tick(); start = 1'b0;
    exp_q.push_back(18'h0ABCD); exp_q.push_back(18'h15555); exp_q.push_back(18'h2AAAA);
    for (int k = 0; k < 13; k++) exp_q.push_back(18'h0);
    host_valid = 1'b1;
    host_instr = 18'h0ABCD; tick();
    host_instr = 18'h15555; tick();
    host_instr = 18'h2AAAA; start = 1'b1; tick();
    start = 1'b0; host_valid = 1'b0;
    chk("pushstart_count", count, 3);
    chk("pushstart_calc_reset", calc_reset, 1);
    run_to_done(c, c0);
    chk("pushstart_done_cycles", c, 35);
    start = 1'b1; tick(); start = 1'b0;

    // reset in the middle of SEND (idx 7)
    for (int k = 0; k < 16; k++) exp_q.push_back({2'b11, 8'(k), 8'hAA});
    host_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      host_instr = {2'b11, 8'(k), 8'hAA};
      tick();
    end
    host_valid = 1'b0;
    repeat (8) tick();
    w = {2'b11, 8'd7, 8'hAA};
    chk("abort_pre_din", calc_din, w);
    chk("abort_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_din", calc_din, 0);
    chk("abort_count", count, 0);
    chk("abort_done", done, 0);
    chk("abort_busy_lat0", busy0, 0);
    @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
    tick();
    chk("post_abort_ready", host_ready, 1);
    chk("post_abort_count", count, 0);
    host_valid = 1'b1; host_instr = 18'h00042; tick(); host_valid = 1'b0;
    chk("post_abort_accept", count, 1);
    chk("post_abort_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_program_loader.md
Name: calc_program_loader

Overview:
- Host-side transmitter for the 16-slot calculator. Buffers up to 16 host instructions and pulses the calculator's reset. Streams the program one word per clock onto the calculator's DIN, then captures the 16 RESULT/NEG values into a result buffer.
- The host reads the result buffer by address. Sits between the host/testbench interface and the calculator instance.

Parameters:
- DEPTH, 16, program slots; the calculator's instruction memory depth (fixed by the calculator, do not change).
- INSTR_W, 18, instruction width {op[17:16], A[15:8], B[7:0]}.
- RES_W, 16, calculator RESULT width.
- RESULT_LATENCY, 2, cycles from the cycle after the last SEND cycle to the first valid calculator result; 0 is legal.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- host_valid  in  1  host offers host_instr.
- host_instr  in  18  instruction word.
- host_ready  out  1  loader accepts a word this cycle.
- start  in  1  begin transmit (FILL) / acknowledge and clear (DONE).
- calc_reset  out  1  registered one-cycle reset pulse to the calculator.
- calc_din  out  18  registered word to the calculator DIN.
- calc_result  in  16  calculator RESULT.
- calc_neg  in  1  calculator NEG.
- busy  out  1  high in RESET_CALC, SEND, WAIT, CAPTURE.
- done  out  1  high in DONE.
- count  out  5  words accepted, 0..16.
- rd_addr  in  4  result buffer read address.
- rd_data  out  17  {neg, result} at rd_addr, registered.

Behaviour:
- Reset (asynchronous): state=FILL, count=0, calc_reset=0, calc_din=0, busy=0, done=0, rd_data=0, result buffer all 0, instruction buffer all 0.
- FILL:
  - host_ready = (count<16), combinational from state/count.
  - A word is accepted when host_valid && host_ready; it goes to buf[count] and count increments.
  - FILL exits to RESET_CALC when a word is accepted and count reaches 16 (auto-start), or when start=1 && count>0.
  - start with count==0 is ignored.
  - Push and start in the same cycle: the word is accepted and included in the program.
  - On exit, slots count..15 are transmitted as 18'h0.
- RESET_CALC: 1 cycle. calc_reset=1, calc_din=0, host_ready=0.
- SEND: exactly 16 cycles, idx 0..15.
  - calc_din=buf[idx] (zero for idx>=count) in the cycle after RESET_CALC, then one word per cycle.
  - calc_reset=0.
  - Next state is WAIT, or CAPTURE if RESULT_LATENCY==0.
- WAIT: RESULT_LATENCY cycles. calc_din=0.
- CAPTURE: exactly 16 cycles, k 0..15. Each cycle, result_buf[k] <= {calc_neg, calc_result}. Next state is DONE.
- DONE:
  - done=1, host_ready=0.
  - start=1 clears count to 0 and returns to FILL. The result buffer is retained until overwritten by the next CAPTURE.
- rd_data: rd_data <= result_buf[rd_addr] every cycle, in any state (1-cycle read latency).
  - A read in the same cycle as a capture write to that address returns the old value.
- host_valid while host_ready=0 is ignored; no word is stored.
- start outside FILL/DONE is ignored.
- Reset asserted mid-operation (any state) aborts immediately to reset values. No partial completion; done stays 0.
- count saturates at 16; no wrap.
- All outputs except host_ready are registered.

Test Plan:
- Full program: push word k = {2'b00, 8'(k), 8'd1} for k=0..15 with host_valid held high -> host_ready low after the 16th accept, count=16. Then calc_reset=1 for exactly one cycle, then calc_din = 18'h00001, 18'h00101 .. 18'h00F01 on 16 consecutive cycles, then calc_din=0.
- Partial program + capture: push 3 words, assert start -> SEND emits 3 words then 13 zero words. With calc_result driven to 16'h1000+k and calc_neg=k[0] during CAPTURE cycle k: done=1 after exactly 1+16+2+16 cycles from start. Reading rd_addr=5 gives rd_data=17'h11005 one cycle later.
- Boundaries: start with count==0 stays in FILL. Push and start in the same cycle with count==2 gives count=3 and transmits 3 words. host_valid during SEND is not accepted and count is unchanged.
- Mid-operation reset: assert reset during SEND idx=7 -> same cycle busy=0, calc_din=0, count=0. After release, state is FILL with host_ready=1.
- DONE/restart: in DONE, assert start -> FILL with count=0 while the old results remain readable. A second full run overwrites all 16 results. RESULT_LATENCY=0 build: capture begins the cycle immediately after the last SEND word.
